// File: rtl/prb_tx.sv
// prb_tx: transmit side of the parameter-registry link.
//
// Takes one acceptance-filter parameter set (11-bit mask, 11-bit code,
// 2-bit SJW) and sends it as a one-cycle header strobe followed by three
// data bytes. A one-deep pending buffer lets the controller issue a new
// set while a frame is still in flight.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   load         single-cycle request to send mask_in/code_in/sjw_in
//   mask_in      acceptance mask (11 bits)
//   code_in      acceptance code (11 bits)
//   sjw_in       sync jump width (2 bits)
//   clr_overrun  clears the sticky overrun flag
//   param_id     frame header strobe, one cycle
//   data         serialised byte, 8'h00 whenever data_valid is low
//   data_valid   high while data carries byte0, byte1 or byte2
//   busy         high whenever the FSM is not IDLE
//   pending      pending buffer holds an unsent set
//   overrun      sticky: a pending set was overwritten before being sent
//   frame_done   one-cycle pulse coincident with byte2
//   state_dbg    current FSM state encoding, for observation only
//
// Handshake: load is a one-cycle request with no back-pressure. It is always
// accepted: straight into the shadow when the FSM can start a frame in that
// cycle, otherwise into the pending buffer (overwriting an unsent set there
// and raising overrun). data is qualified by data_valid; there is no ready.
//
// Byte packing from the shadow {S, C, M}:
//   byte0 = M[7:0]
//   byte1 = {C[4:0], M[10:8]}
//   byte2 = {S[1:0], C[10:5]}
module prb_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [10:0] mask_in,
    input  logic [10:0] code_in,
    input  logic [1:0]  sjw_in,
    input  logic        clr_overrun,
    output logic        param_id,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        busy,
    output logic        pending,
    output logic        overrun,
    output logic        frame_done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        B0   = 3'd2,
        B1   = 3'd3,
        B2   = 3'd4,
        GAP  = 3'd5
    } state_t;

    // A zero-gap build never uses the counter; keep it one bit wide so the
    // declaration stays legal.
    localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] GAP_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] gap_cnt_q, gap_cnt_d;

    // Parameter sets are held as {sjw[1:0], code[10:0], mask[10:0]}.
    logic [23:0]   shadow_q, shadow_d;
    logic [23:0]   pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic          overrun_d;
    logic          overrun_set;
    logic          decide;
    logic [23:0]   in_set;

    logic          param_id_d;
    logic [7:0]    data_d;
    logic          data_valid_d;
    logic          frame_done_d;
    logic          busy_d;

    logic [10:0]   sh_mask;
    logic [10:0]   sh_code;
    logic [1:0]    sh_sjw;

    assign in_set  = {sjw_in, code_in, mask_in};
    assign sh_mask = shadow_q[10:0];
    assign sh_code = shadow_q[21:11];
    assign sh_sjw  = shadow_q[23:22];

    assign state_dbg = state_q;
    assign pending   = pend_valid_q;

    // Next-state, buffer management and next-output decode.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        overrun_set  = 1'b0;
        decide       = 1'b0;

        case (state_q)
            IDLE: decide = 1'b1;
            HDR:  state_d = B0;
            B0:   state_d = B1;
            B1:   state_d = B2;
            B2: begin
                if (GAP_CYCLES == 0) begin
                    decide = 1'b1;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            GAP: begin
                // The last gap cycle makes the idle decision itself, so no
                // extra IDLE cycle is inserted between frames.
                if (gap_cnt_q <= GAP_ONE) begin
                    decide = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (decide) begin
            if (pend_valid_q) begin
                // Pending set goes out first; a simultaneous load refills
                // the now-free buffer without raising overrun.
                shadow_d     = pend_q;
                state_d      = HDR;
                pend_valid_d = load;
                if (load) begin
                    pend_d = in_set;
                end
            end else if (load) begin
                shadow_d = in_set;
                state_d  = HDR;
            end else begin
                state_d = IDLE;
            end
        end else if (load) begin
            pend_d       = in_set;
            pend_valid_d = 1'b1;
            if (pend_valid_q) begin
                overrun_set = 1'b1;
            end
        end

        // Setting wins over clearing when both happen in the same cycle.
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun;
        end

        // Outputs are registered, so they are decoded from the next state.
        // The shadow only changes when entering HDR, whose data is 00, so
        // the byte contents can come from the current shadow.
        param_id_d   = (state_d == HDR);
        data_valid_d = (state_d == B0) || (state_d == B1) || (state_d == B2);
        frame_done_d = (state_d == B2);
        busy_d       = (state_d != IDLE);
        case (state_d)
            B0:      data_d = sh_mask[7:0];
            B1:      data_d = {sh_code[4:0], sh_mask[10:8]};
            B2:      data_d = {sh_sjw, sh_code[10:5]};
            default: data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            shadow_q     <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            overrun      <= 1'b0;
            param_id     <= 1'b0;
            data         <= 8'h00;
            data_valid   <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            overrun      <= overrun_d;
            param_id     <= param_id_d;
            data         <= data_d;
            data_valid   <= data_valid_d;
            frame_done   <= frame_done_d;
            busy         <= busy_d;
        end
    end

endmodule
